// File: rtl/arb_pkg.sv
// Shared types for the round-robin packet arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pry2oht_bck.sv
// Priority encoder: keeps only the highest-priority set bit of dat_i as a one-hot word.
module pry2oht_bck #(
    parameter int WIDTH          = 4,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    parameter     DIRECTION      = "LSB"
) (
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] oht_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] dat_s;
    logic [WIDTH-1:0] oht_s;
    logic             found_s;

    // MSB priority reuses the LSB encoder on a bit-reversed word
    if (DIRECTION == "MSB") begin : g_msb
        for (genvar i = 0; i < WIDTH; i++) begin : g_rev
            assign dat_s[i] = dat_i[WIDTH-1-i];
            assign oht_o[i] = oht_s[WIDTH-1-i];
        end
    end else begin : g_lsb
        assign dat_s = dat_i;
        assign oht_o = oht_s;
    end

    if (IMPLEMENTATION == 0 || SPLIT < 2) begin : g_arith
        assign oht_s   = dat_s & (~dat_s + WIDTH'(1));
        assign found_s = 1'b0;
    end else begin : g_scan
        // Linear scan: first set bit wins
        always_comb begin
            oht_s   = '0;
            found_s = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (dat_s[i] && !found_s) begin
                    oht_s[i] = 1'b1;
                    found_s  = 1'b1;
                end else begin
                    oht_s[i] = 1'b0;
                end
            end
        end
    end

    assign vld_o = |dat_i;

endmodule

// File: rtl/arb_rr_pkt.sv
// Round-robin packet arbiter: grants one requester per packet and holds the
// grant until the last beat transfers, then rotates priority past the winner.
module arb_rr_pkt
    import arb_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [WIDTH-1:0]         req_vld,
    input  logic [WIDTH-1:0]         req_lst,
    output logic [WIDTH-1:0]         req_rdy,
    output logic                     out_vld,
    output logic                     out_lst,
    input  logic                     out_rdy,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_idx
);

    localparam int IW = $clog2(WIDTH);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] msk_q, msk_d;
    logic [WIDTH-1:0] pick_msk_s, pick_unm_s, pick_s;
    logic             msk_hit_s, any_req_s, xfer_s;
    logic             out_vld_s, out_lst_s;
    logic [WIDTH-1:0] req_rdy_s;
    logic [IW-1:0]    gnt_idx_s;

    pry2oht_bck #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION), .DIRECTION("LSB")
    ) u_pry_msk (
        .dat_i(req_vld & msk_q),
        .oht_o(pick_msk_s),
        .vld_o(msk_hit_s)
    );

    pry2oht_bck #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION), .DIRECTION("LSB")
    ) u_pry_unm (
        .dat_i(req_vld),
        .oht_o(pick_unm_s),
        .vld_o(any_req_s)
    );

    assign pick_s = msk_hit_s ? pick_msk_s : pick_unm_s;
    assign xfer_s = out_vld_s & out_rdy;

    // State, grant and priority-mask registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            msk_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            msk_q   <= msk_d;
        end
    end

    // Next-state: grant on request in IDLE, release after the last beat
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        msk_d   = msk_q;
        case (state_q)
            IDLE: begin
                if (ena && any_req_s) begin
                    state_d = BUSY;
                    gnt_d   = pick_s;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            BUSY: begin
                if (xfer_s && out_lst_s) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    // Bits strictly above the winner; the top index wraps to 0
                    msk_d   = ~(gnt_q | (gnt_q - WIDTH'(1)));
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                msk_d   = '0;
            end
        endcase
    end

    // Stream muxing follows the locked grant only while BUSY
    always_comb begin
        out_vld_s = 1'b0;
        out_lst_s = 1'b0;
        req_rdy_s = '0;
        case (state_q)
            BUSY: begin
                out_vld_s = |(req_vld & gnt_q);
                out_lst_s = |(req_lst & gnt_q);
                req_rdy_s = gnt_q & {WIDTH{out_rdy}};
            end
            default: begin
                out_vld_s = 1'b0;
                out_lst_s = 1'b0;
                req_rdy_s = '0;
            end
        endcase
    end

    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt_q[i]) begin
                gnt_idx_s = gnt_idx_s | IW'(i);
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    assign out_vld = out_vld_s & rst_n;
    assign out_lst = out_lst_s & rst_n;
    assign req_rdy = req_rdy_s & {WIDTH{rst_n}};
    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_s;

endmodule

// File: tb/tb_arb_rr_pkt.sv
// Directed bench for arb_rr_pkt with a round-robin reference model checked every cycle.
module tb_arb_rr_pkt;

    logic       clk = 1'b0;
    logic       rst_n, ena, out_rdy;
    logic [3:0] req_vld, req_lst, req_rdy, gnt;
    logic       out_vld, out_lst;
    logic [1:0] gnt_idx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arb_rr_pkt #(.WIDTH(4), .SPLIT(2), .IMPLEMENTATION(0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_vld(req_vld), .req_lst(req_lst), .req_rdy(req_rdy),
        .out_vld(out_vld), .out_lst(out_lst), .out_rdy(out_rdy),
        .gnt(gnt), .gnt_idx(gnt_idx)
    );

    // Reference model: packet owner and last winner, searched round-robin
    bit m_busy = 1'b0;
    int m_g    = 0;
    int m_last = -1;
    bit chk_en = 1'b0;

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int i = last + 1; i < 4; i++) if (v[i]) return i;
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = -1;
            chk_en = 1'b1;
        end else if (!m_busy) begin
            if (ena && req_vld != 4'b0000) begin
                m_g    = rr_pick(req_vld, m_last);
                m_busy = 1'b1;
            end
        end else if (req_vld[m_g] && out_rdy && req_lst[m_g]) begin
            m_busy = 1'b0;
            m_last = m_g;
        end
    end

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [3:0] one, e_gnt, e_rdy;
        logic [1:0] e_idx;
        logic       e_vld, e_lst;
        if (chk_en) begin
            one   = 4'b0001;
            e_gnt = m_busy ? (one << m_g) : 4'b0000;
            e_idx = m_busy ? 2'(m_g) : 2'b00;
            e_vld = rst_n && m_busy && req_vld[m_g];
            e_lst = rst_n && m_busy && req_lst[m_g];
            e_rdy = (rst_n && m_busy && out_rdy) ? e_gnt : 4'b0000;
            check("m_gnt", gnt, e_gnt);
            check("m_idx", {2'b00, gnt_idx}, {2'b00, e_idx});
            check("m_vld", {3'b000, out_vld}, {3'b000, e_vld});
            check("m_lst", {3'b000, out_lst}, {3'b000, e_lst});
            check("m_rdy", req_rdy, e_rdy);
        end
    end

    task automatic tick_chk(input string nm, input logic [3:0] exp);
        @(posedge clk);
        #2;
        check(nm, gnt, exp);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ena     = 1'b0;
        req_vld = 4'b0000;
        req_lst = 4'b0000;
        out_rdy = 1'b0;
        tick_chk("rst_a", 4'b0000);
        tick_chk("rst_b", 4'b0000);
        check("rst_idx", {2'b00, gnt_idx}, 4'b0000);
        rst_n = 1'b1;
    endtask

    logic [3:0] e033 [6] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0] e034 [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    initial begin
        rst_n = 1'b0; ena = 1'b0; req_vld = 4'b0000; req_lst = 4'b0000; out_rdy = 1'b0;
        do_reset();

        // Two requesters alternate
        ena = 1'b1; req_vld = 4'b1010; req_lst = 4'b1111; out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) tick_chk($sformatf("r033_%0d", i), e033[i]);
        req_vld = 4'b0000;
        tick_chk("r033_end", 4'b0000);

        // All requesting: full rotation with bubbles
        do_reset();
        ena = 1'b1; req_vld = 4'b1111; req_lst = 4'b1111; out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) tick_chk($sformatf("r034_%0d", i), e034[i]);
        req_vld = 4'b0000;
        tick_chk("r034_end", 4'b0000);

        // Three-beat packet with backpressure, competitor locked out
        do_reset();
        ena = 1'b1; req_vld = 4'b0100; req_lst = 4'b0000; out_rdy = 1'b0;
        tick_chk("r035_gnt", 4'b0100);
        req_vld = 4'b0101; out_rdy = 1'b1;
        #1 check("r035_rdy1", req_rdy, 4'b0100);
        tick_chk("r035_b1", 4'b0100);
        out_rdy = 1'b0;
        tick_chk("r035_w1", 4'b0100);
        out_rdy = 1'b1;
        tick_chk("r035_b2", 4'b0100);
        out_rdy = 1'b0; req_lst = 4'b0100;
        #1 check("r035_rdy0", req_rdy, 4'b0000);
        tick_chk("r035_w2", 4'b0100);
        out_rdy = 1'b1;
        #1 check("r035_lst", {3'b000, out_lst}, 4'b0001);
        tick_chk("r035_b3", 4'b0000);
        tick_chk("r035_next", 4'b0001);
        req_lst = 4'b0101;
        tick_chk("r035_done", 4'b0000);
        req_vld = 4'b0000;
        tick_chk("r035_end", 4'b0000);

        // Enable gating in IDLE
        do_reset();
        ena = 1'b0; req_vld = 4'b0001; req_lst = 4'b1111; out_rdy = 1'b1;
        tick_chk("r036_off0", 4'b0000);
        tick_chk("r036_off1", 4'b0000);
        tick_chk("r036_off2", 4'b0000);
        ena = 1'b1;
        tick_chk("r036_on", 4'b0001);
        tick_chk("r036_done", 4'b0000);
        req_vld = 4'b0000;

        // Reset mid-packet clears grant and mask
        do_reset();
        ena = 1'b1; req_vld = 4'b0001; req_lst = 4'b1111; out_rdy = 1'b1;
        tick_chk("r037_g0", 4'b0001);
        tick_chk("r037_d0", 4'b0000);
        req_vld = 4'b0010; req_lst = 4'b0000;
        tick_chk("r037_g1", 4'b0010);
        tick_chk("r037_beat", 4'b0010);
        rst_n = 1'b0;
        #1 check("r037_vld_rst", {3'b000, out_vld}, 4'b0000);
        tick_chk("r037_rst", 4'b0000);
        check("r037_idx", {2'b00, gnt_idx}, 4'b0000);
        rst_n = 1'b1; req_vld = 4'b0011; req_lst = 4'b0011;
        tick_chk("r037_after", 4'b0001);
        tick_chk("r037_done", 4'b0000);
        req_vld = 4'b0000;

        // Wrap-around after the top index
        do_reset();
        ena = 1'b1; req_vld = 4'b1000; req_lst = 4'b1111; out_rdy = 1'b1;
        tick_chk("r038_g3", 4'b1000);
        check("r038_idx3", {2'b00, gnt_idx}, 4'b0011);
        tick_chk("r038_d3", 4'b0000);
        req_vld = 4'b1001;
        tick_chk("r038_wrap", 4'b0001);
        tick_chk("r038_done", 4'b0000);
        req_vld = 4'b0000;
        tick_chk("r038_end", 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_rr_pkt.md
ARB_RR_PKT -- requirements
Module: arb_rr_pkt

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of requesters (>=2).
REQ-002 SHALL have parameter SPLIT, default 2, tree split factor passed to priority encoders.
REQ-003 SHALL have parameter IMPLEMENTATION, default 0, encoder implementation select passed through.
REQ-004 SHALL have port clk  input  1  clock; one clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ena  input  1  arbitration enable; low blocks new grants only.
REQ-007 SHALL have port req_vld  input  WIDTH  per-requester valid.
REQ-008 SHALL have port req_lst  input  WIDTH  per-requester last-beat of packet.
REQ-009 SHALL have port req_rdy  output  WIDTH  per-requester ready.
REQ-010 SHALL have port out_vld  output  1  merged stream valid.
REQ-011 SHALL have port out_lst  output  1  merged stream last.
REQ-012 SHALL have port out_rdy  input  1  downstream ready.
REQ-013 SHALL have port gnt  output  WIDTH  registered one-hot grant, zero when idle.
REQ-014 SHALL have port gnt_idx  output  $clog2(WIDTH)  binary index of gnt, 0 when idle.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 In IDLE with ena=1 and |req_vld, SHALL next cycle enter BUSY with gnt = round-robin pick; else stay IDLE.
REQ-017 Pick SHALL be lowest-index set bit of req_vld & msk; if that is zero, lowest-index set bit of req_vld.
REQ-018 msk SHALL be a WIDTH-bit register; bits strictly above last granted index set, others clear.
REQ-019 Grant latency SHALL be exactly 1 cycle from request sampled in IDLE to gnt valid.
REQ-020 In BUSY: out_vld = |(req_vld & gnt); out_lst = |(req_lst & gnt); req_rdy = gnt & {WIDTH{out_rdy}}; non-granted req_rdy SHALL be 0.
REQ-021 Transfer SHALL occur when out_vld & out_rdy.
REQ-022 Grant SHALL be held (locked) through all beats until transfer with out_lst=1; req_vld drop mid-packet SHALL NOT release grant.
REQ-023 On last transfer SHALL return to IDLE, clear gnt, and load msk from granted index; one idle bubble precedes next grant.
REQ-024 ena deassert in BUSY SHALL NOT abort the packet; only affects IDLE decision.
REQ-025 In IDLE, out_vld, out_lst and req_rdy SHALL be 0.
REQ-026 Granted index WIDTH-1 SHALL produce msk=0 (wrap-around to index 0 priority).
REQ-027 Single requester SHALL be re-granted after each packet (bubble between packets).

Reset
REQ-028 rst_n=0 at clock edge SHALL force state IDLE, gnt=0, gnt_idx=0, msk=0, regardless of packet in progress.
REQ-029 Outputs during and one cycle after reset SHALL be all zero; arbitration resumes first edge with rst_n=1.

Structure
REQ-030 State enum (IDLE, BUSY) SHALL reside in shared package arb_pkg.
REQ-031 SHALL instantiate pry2oht_bck twice (masked, unmasked), DIRECTION "LSB", WIDTH/SPLIT/IMPLEMENTATION forwarded; no new sub-module.
REQ-032 One-hot to index SHALL be combinational OR-reduction inside this module.

Verification (WIDTH=4)
REQ-033 Reset then req_vld=4'b1010, lst=all 1, out_rdy=1 -> gnt 4'b0010 cycle 1, IDLE, gnt 4'b1000, IDLE, gnt 4'b0010.
REQ-034 req_vld=4'b1111 constant, single-beat packets -> grant order idx 0,1,2,3,0 with one bubble between.
REQ-035 Requester 2 sends 3-beat packet, out_rdy toggles 1,0,1,0,1 -> gnt stays 4'b0100 until third accepted beat; requester 0 valid meanwhile gets req_rdy=0.
REQ-036 ena=0 with req_vld=4'b0001 -> gnt stays 0; ena=1 -> gnt 4'b0001 next cycle.
REQ-037 rst_n=0 mid-packet on requester 1 -> gnt=0, msk=0 next cycle; after release, req_vld=4'b0011 -> gnt 4'b0001.
REQ-038 Grant idx 3 then req_vld=4'b1001 -> next gnt 4'b0001 (wrap-around).
